// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-addressable data memory, load alignment/extension, branch decision.
// Define MEM_STAGE_DEBUG_PORT_EN to add a combinational debug read port.
module mem_stage #(
  parameter int NB_ADDR     = 5,
  parameter int NB_DATA     = 32,
  parameter int NB_MEM_ADDR = 10
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_valid,
  input  logic                   i_data_mem_wr_enb,
  input  logic                   i_data_mem_rd_enb,
  input  logic                   i_is_branch_instruction,
  input  logic [NB_DATA-1:0]     i_alu_result,
  input  logic                   i_alu_zero,
  input  logic [NB_DATA-1:0]     i_branch_addr,
  input  logic [NB_DATA-1:0]     i_rf_rt_data,
  input  logic [1:0]             i_mem_width,
  input  logic                   i_load_signed,
  input  logic                   i_rf_wr_enb,
  input  logic                   i_rf_wr_data_src,
  input  logic [NB_ADDR-1:0]     i_rf_wr_addr,
`ifdef MEM_STAGE_DEBUG_PORT_EN
  input  logic [NB_MEM_ADDR-1:0] i_dbg_mem_addr,
  output logic [NB_DATA-1:0]     o_dbg_mem_data,
`endif
  output logic                   o_pc_src,
  output logic [NB_DATA-1:0]     o_branch_addr,
  output logic [NB_DATA-1:0]     o_mem_rd_data_ltchd,
  output logic [NB_DATA-1:0]     o_alu_result_ltchd,
  output logic                   o_rf_wr_enb_ltchd,
  output logic                   o_rf_wr_data_src_ltchd,
  output logic [NB_ADDR-1:0]     o_rf_wr_addr_ltchd,
  output logic                   o_misaligned_ltchd
);
  localparam int DEPTH = 2**NB_MEM_ADDR;
  localparam int LANES = NB_DATA/8;

  logic [NB_DATA-1:0]     mem [DEPTH];
  logic [NB_MEM_ADDR-1:0] idx;
  logic [1:0]             boff;
  logic                   misaligned;
  logic                   store;
  logic [LANES-1:0]       be;
  logic [NB_DATA-1:0]     wdata;
  logic [NB_DATA-1:0]     rword;
  logic [7:0]             rbyte;
  logic [15:0]            rhalf;
  logic [NB_DATA-1:0]     rext;
  logic [NB_DATA-1:0]     rd_next;
  logic                   unused_addr;

  assign idx         = i_alu_result[NB_MEM_ADDR+1:2];
  assign boff        = i_alu_result[1:0];
  assign unused_addr = ^i_alu_result[NB_DATA-1:NB_MEM_ADDR+2];

  assign o_pc_src      = i_valid & i_is_branch_instruction & i_alu_zero;
  assign o_branch_addr = i_branch_addr;

  // Reserved width 11 follows the word rules.
  always_comb begin
    misaligned = 1'b0;
    case (i_mem_width)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = boff[0];
      default: misaligned = (boff != 2'b00);
    endcase
  end

  // Replicate the low store data across lanes; byte enables pick the live ones.
  always_comb begin
    be    = '0;
    wdata = i_rf_rt_data;
    case (i_mem_width)
      2'b00: begin
        be[boff] = 1'b1;
        wdata    = {LANES{i_rf_rt_data[7:0]}};
      end
      2'b01: begin
        be    = boff[1] ? 4'b1100 : 4'b0011;
        wdata = {(LANES/2){i_rf_rt_data[15:0]}};
      end
      default: be = '1;
    endcase
  end

  // Reset level is sampled here so a store presented during reset never lands.
  assign store = i_reset_n & i_valid & i_data_mem_wr_enb & ~misaligned;

  always_ff @(posedge i_clock) begin
    if (store) begin
      for (int l = 0; l < LANES; l++)
        if (be[l]) mem[idx][l*8 +: 8] <= wdata[l*8 +: 8];
    end
  end

  assign rword = mem[idx];
  assign rbyte = rword[{boff, 3'b000} +: 8];
  assign rhalf = rword[{boff[1], 4'b0000} +: 16];

  always_comb begin
    rext = rword;
    case (i_mem_width)
      2'b00:   rext = {{(NB_DATA-8){i_load_signed & rbyte[7]}}, rbyte};
      2'b01:   rext = {{(NB_DATA-16){i_load_signed & rhalf[15]}}, rhalf};
      default: rext = rword;
    endcase
  end

  assign rd_next = (i_valid & i_data_mem_rd_enb & ~misaligned) ? rext : '0;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_mem_rd_data_ltchd    <= '0;
      o_alu_result_ltchd     <= '0;
      o_rf_wr_enb_ltchd      <= 1'b0;
      o_rf_wr_data_src_ltchd <= 1'b0;
      o_rf_wr_addr_ltchd     <= '0;
      o_misaligned_ltchd     <= 1'b0;
    end else begin
      o_mem_rd_data_ltchd    <= rd_next;
      o_alu_result_ltchd     <= i_alu_result;
      o_rf_wr_enb_ltchd      <= i_rf_wr_enb & i_valid & ~misaligned;
      o_rf_wr_data_src_ltchd <= i_rf_wr_data_src;
      o_rf_wr_addr_ltchd     <= i_rf_wr_addr;
      o_misaligned_ltchd     <= i_valid & (i_data_mem_rd_enb | i_data_mem_wr_enb) & misaligned;
    end
  end

`ifdef MEM_STAGE_DEBUG_PORT_EN
  assign o_dbg_mem_data = mem[i_dbg_mem_addr];
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes expected latched results, monitor pops and compares.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, wr, rd, br, zero, sgn, rfwe, src;
  logic [31:0] alu, baddr, rt;
  logic [1:0]  width;
  logic [4:0]  ra;
  logic        pc_src, rf_we_l, src_l, mis_l;
  logic [31:0] baddr_o, rd_l, alu_l;
  logic [4:0]  ra_l;
`ifdef MEM_STAGE_DEBUG_PORT_EN
  logic [9:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] alu;
    logic        we;
    logic        src;
    logic        mis;
    logic [4:0]  ra;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_valid(valid),
    .i_data_mem_wr_enb(wr), .i_data_mem_rd_enb(rd),
    .i_is_branch_instruction(br), .i_alu_result(alu), .i_alu_zero(zero),
    .i_branch_addr(baddr), .i_rf_rt_data(rt), .i_mem_width(width),
    .i_load_signed(sgn), .i_rf_wr_enb(rfwe), .i_rf_wr_data_src(src),
    .i_rf_wr_addr(ra),
`ifdef MEM_STAGE_DEBUG_PORT_EN
    .i_dbg_mem_addr(dbg_addr), .o_dbg_mem_data(dbg_data),
`endif
    .o_pc_src(pc_src), .o_branch_addr(baddr_o),
    .o_mem_rd_data_ltchd(rd_l), .o_alu_result_ltchd(alu_l),
    .o_rf_wr_enb_ltchd(rf_we_l), .o_rf_wr_data_src_ltchd(src_l),
    .o_rf_wr_addr_ltchd(ra_l), .o_misaligned_ltchd(mis_l)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Drive one instruction now (no edge wait) and queue its expected latched result.
  task automatic drive(input bit v, w, r, input logic [31:0] a, d, input logic [1:0] wd,
                       input bit s, we, sr, input logic [4:0] rad,
                       input logic [31:0] exp_rd, input bit exp_mis, input bit exp_we);
    exp_t e;
    valid = v; wr = w; rd = r; alu = a; rt = d; width = wd;
    sgn = s; rfwe = we; src = sr; ra = rad; br = 1'b0; zero = 1'b0;
    e.rd = exp_rd; e.alu = a; e.we = exp_we; e.src = sr; e.mis = exp_mis; e.ra = rad;
    q.push_back(e);
  endtask

  task automatic op(input bit v, w, r, input logic [31:0] a, d, input logic [1:0] wd,
                    input bit s, we, sr, input logic [4:0] rad,
                    input logic [31:0] exp_rd, input bit exp_mis, input bit exp_we);
    @(negedge clk);
    drive(v, w, r, a, d, wd, s, we, sr, rad, exp_rd, exp_mis, exp_we);
  endtask

  task automatic sw(input logic [31:0] a, d, input logic [1:0] wd);
    op(1, 1, 0, a, d, wd, 0, 0, 0, 5'd0, 32'h0, 0, 0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] wd, input bit s,
                    input logic [31:0] exp_rd);
    op(1, 0, 1, a, 32'h0, wd, s, 1, 1, 5'd3, exp_rd, 0, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    valid = 0; wr = 0; rd = 0; rfwe = 0; br = 0; zero = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rd_data", rd_l, e.rd);
        chk("alu_l", alu_l, e.alu);
        chk("rf_we", {31'b0, rf_we_l}, {31'b0, e.we});
        chk("src", {31'b0, src_l}, {31'b0, e.src});
        chk("mis", {31'b0, mis_l}, {31'b0, e.mis});
        chk("ra", {27'b0, ra_l}, {27'b0, e.ra});
      end
    end
  end

  initial begin : stim
    int budget;
    rst_n = 1'b0;
    valid = 0; wr = 0; rd = 0; br = 0; zero = 0; sgn = 0; rfwe = 0; src = 0;
    alu = '0; baddr = '0; rt = '0; width = 2'b10; ra = '0;
    #1;
    chk("reset_rd", rd_l, 32'h0);
    chk("reset_flags", {29'b0, rf_we_l, src_l, mis_l}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Word store then load into r5
    sw(32'h10, 32'hDEADBEEF, 2'b10);
    op(1, 0, 1, 32'h10, 32'h0, 2'b10, 0, 1, 1, 5'd5, 32'hDEADBEEF, 0, 1);

    // Extension cases on 0x80FF7F01
    sw(32'h20, 32'h80FF7F01, 2'b10);
    ld(32'h23, 2'b00, 1, 32'hFFFFFF80);
    ld(32'h23, 2'b00, 0, 32'h00000080);
    ld(32'h22, 2'b01, 1, 32'hFFFF80FF);
    ld(32'h20, 2'b01, 0, 32'h00007F01);
    ld(32'h21, 2'b00, 1, 32'h0000007F);

    // Misaligned word load: flag pulses once, no write-back, memory intact
    op(1, 0, 1, 32'h22, 32'h0, 2'b10, 0, 1, 0, 5'd7, 32'h0, 1, 0);
    ld(32'h20, 2'b10, 0, 32'h80FF7F01);

    // Halfword and byte stores only touch their lanes
    sw(32'h12, 32'hAAAA5555, 2'b01);
    ld(32'h10, 2'b10, 0, 32'h5555BEEF);
    sw(32'h11, 32'h000000C3, 2'b00);
    ld(32'h10, 2'b10, 0, 32'h5555C3EF);

    // Misaligned word store and halfword load
    op(1, 1, 0, 32'h11, 32'h11111111, 2'b10, 0, 0, 0, 5'd0, 32'h0, 1, 0);
    op(1, 0, 1, 32'h13, 32'h0, 2'b01, 1, 1, 1, 5'd9, 32'h0, 1, 0);
    ld(32'h10, 2'b10, 0, 32'h5555C3EF);

    // Simultaneous store + load returns old contents
    op(1, 1, 1, 32'h20, 32'h01020304, 2'b10, 0, 1, 1, 5'd4, 32'h80FF7F01, 0, 1);
    ld(32'h20, 2'b10, 0, 32'h01020304);

    // Reserved width behaves as word
    ld(32'h20, 2'b11, 0, 32'h01020304);
    op(1, 0, 1, 32'h21, 32'h0, 2'b11, 0, 1, 1, 5'd2, 32'h0, 1, 0);

    // Address wrap, then bubbles must not write or flag
    sw(32'h1000, 32'h12345678, 2'b10);
    ld(32'h0, 2'b10, 0, 32'h12345678);
    op(0, 1, 0, 32'h0, 32'hFFFFFFFF, 2'b10, 0, 1, 0, 5'd1, 32'h0, 0, 0);
    op(0, 1, 0, 32'h3, 32'hFFFFFFFF, 2'b10, 0, 1, 0, 5'd1, 32'h0, 0, 0);
    ld(32'h0, 2'b10, 0, 32'h12345678);

    // Combinational branch decision
    idle();
    valid = 1; br = 1; zero = 1; baddr = 32'h40;
    #1;
    chk("pc_src_taken", {31'b0, pc_src}, 32'h1);
    chk("branch_addr", baddr_o, 32'h40);
    valid = 0;
    #1;
    chk("pc_src_bubble", {31'b0, pc_src}, 32'h0);
    valid = 1; zero = 0;
    #1;
    chk("pc_src_nz", {31'b0, pc_src}, 32'h0);

    // Async reset while a store is presented; no queued expectation for it
    idle();
    ld(32'h20, 2'b10, 0, 32'h01020304);
    @(negedge clk);
    valid = 1; wr = 1; rd = 0; rfwe = 1; alu = 32'h20; rt = 32'hCAFEF00D; width = 2'b10; ra = 5'd6;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rd", rd_l, 32'h0);
    chk("rst_alu", alu_l, 32'h0);
    chk("rst_flags", {24'b0, ra_l, rf_we_l, src_l, mis_l}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 1, 32'h20, 32'h0, 2'b10, 0, 1, 0, 5'd8, 32'h01020304, 0, 1);
    idle();

    budget = 0;
    while (q.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- NB_ADDR, 5, register-file address width.
- NB_DATA, 32, datapath width.
- NB_MEM_ADDR, 10, data-memory word-address width; depth is 2**NB_MEM_ADDR words.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- i_clock, in, 1, the single clock; all state changes on the rising edge.
- i_reset_n, in, 1, asynchronous active-low reset.
- i_valid, in, 1, the execute-stage bundle is a real instruction (0 = bubble).
- i_data_mem_wr_enb, in, 1, store.
- i_data_mem_rd_enb, in, 1, load.
- i_is_branch_instruction, in, 1, conditional branch.
- i_alu_result, in, NB_DATA, byte address, or the ALU value passed through.
- i_alu_zero, in, 1, ALU zero flag.
- i_branch_addr, in, NB_DATA, branch target.
- i_rf_rt_data, in, NB_DATA, store data.
- i_mem_width, in, 2, access width: 00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- i_load_signed, in, 1, sign-extend loads narrower than a word.
- i_rf_wr_enb, in, 1, register write.
- i_rf_wr_data_src, in, 1, write-back source: 1 = memory, 0 = ALU.
- i_rf_wr_addr, in, NB_ADDR, destination register.
- o_pc_src, out, 1, branch taken (combinational).
- o_branch_addr, out, NB_DATA, i_branch_addr passed through (combinational).
- o_mem_rd_data_ltchd, out, NB_DATA, aligned and extended load data.
- o_alu_result_ltchd, out, NB_DATA, latched ALU result.
- o_rf_wr_enb_ltchd, out, 1, latched register write.
- o_rf_wr_data_src_ltchd, out, 1, latched write-back source.
- o_rf_wr_addr_ltchd, out, NB_ADDR, latched destination register.
- o_misaligned_ltchd, out, 1, one-cycle misalignment flag.

Function
REQ-003 o_pc_src SHALL equal i_valid & i_is_branch_instruction & i_alu_zero, combinationally.

REQ-004 Word index SHALL be i_alu_result[NB_MEM_ADDR+1:2]; upper address bits are ignored, so addresses wrap modulo the memory depth.

REQ-005 Alignment SHALL be decided as follows; any other case is misaligned.
- Halfword requires i_alu_result[0]=0.
- Word requires i_alu_result[1:0]=00.
- Byte is always aligned.

REQ-006 A store SHALL occur on the clock edge when i_valid=1, wr_enb=1 and the access is aligned.
- It writes only the addressed lanes: byte → lane addr[1:0]; halfword → lanes addr[1]*2 and +1; word → all four.
- Store data is taken from the low bits of i_rf_rt_data, little-endian.

REQ-007 Memory read SHALL be asynchronous on the word index.
- The selected byte or halfword is right-justified.
- It is zero- or sign-extended per i_load_signed, then latched into o_mem_rd_data_ltchd: one-cycle latency, aligned with the other _ltchd outputs.

REQ-008 When a load is not enabled, or the access is misaligned, o_mem_rd_data_ltchd SHALL latch 0.

REQ-009 With rd and wr both asserted in one cycle, the store SHALL execute and the load SHALL return the pre-store contents.

REQ-010 On every edge, o_alu_result_ltchd, o_rf_wr_data_src_ltchd and o_rf_wr_addr_ltchd SHALL latch their inputs unconditionally.

REQ-011 o_rf_wr_enb_ltchd SHALL latch i_rf_wr_enb & i_valid & ~misaligned_mem_access.

REQ-012 o_misaligned_ltchd SHALL latch i_valid & (rd|wr) & misaligned, a single-cycle pulse per offending instruction.

REQ-013 Bubbles (i_valid=0) SHALL NOT write memory, the register file, or raise any flag.

Reset
REQ-014 Asserting i_reset_n=0 SHALL immediately clear every _ltchd output to 0.
- Memory contents are not reset.
- o_pc_src and o_branch_addr remain combinational.

REQ-015 While reset is asserted, no memory write SHALL occur, including a store pending mid-cycle.

REQ-016 The first edge after deassertion SHALL behave as a normal cycle.

Configuration
REQ-017 Macro MEM_STAGE_DEBUG_PORT_EN SHALL control a debug read port.
- Defined: adds i_dbg_mem_addr (in, NB_MEM_ADDR, word index) and o_dbg_mem_data (out, NB_DATA, combinational read of that word), for the debug unit; this has no effect on pipeline behaviour.
- Undefined: both ports are absent and no debug logic exists.

Verification
REQ-018 Word store then load:
- Stimulus: SW 0xDEADBEEF at addr 0x10, then LW 0x10 with wr_enb=1, addr=5.
- Response: o_mem_rd_data_ltchd=0xDEADBEEF one cycle after the LW, o_rf_wr_enb_ltchd=1, o_rf_wr_addr_ltchd=5.

REQ-019 Byte sign/zero extension:
- Stimulus: store word 0x80FF7F01 at 0x20, then LB 0x23 signed, then LBU 0x23, then LH 0x22 signed.
- Response: 0xFFFFFF80, 0x00000080, 0xFFFF80FF respectively.

REQ-020 Misaligned word load:
- Stimulus: LW at 0x22 with wr_enb=1.
- Response: o_misaligned_ltchd=1 for one cycle, o_rf_wr_enb_ltchd=0, o_mem_rd_data_ltchd=0, memory unchanged.

REQ-021 Branch decision:
- Stimulus: i_is_branch_instruction=1, i_alu_zero=1, i_valid=1, i_branch_addr=0x40.
- Response: same-cycle o_pc_src=1, o_branch_addr=0x40; with i_valid=0, o_pc_src=0.

REQ-022 Wrap and bubble:
- Stimulus: SW 0x12345678 at byte address 4*2**NB_MEM_ADDR; then a bubble SW 0xFFFFFFFF at 0.
- Response: word 0 reads 0x12345678, and the bubble causes no write.

REQ-023 Asynchronous reset mid-store:
- Stimulus: drive i_reset_n=0 between edges while SW is presented.
- Response: all _ltchd outputs go to 0 immediately, and the target word is unchanged.
